// File: rtl/dds_pkg.sv
// ============================================================================
// dds_pkg : widths and crossing-state encoding shared by the DDS blocks
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dds_pkg;

    localparam int DATA_W = 10;
    localparam int FREQ_W = 20;

    localparam logic [DATA_W-1:0] C_DATA_MAX = '1;
    localparam logic [FREQ_W-1:0] C_FREQ_MAX = '1;

    typedef enum logic {
        CROSS_LOW  = 1'b0,
        CROSS_HIGH = 1'b1
    } cross_state_e;

endpackage

`default_nettype wire

// File: rtl/wave_cross_det.sv
// ============================================================================
// wave_cross_det : hysteresis comparator around thr, pulses on LOW->HIGH
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wave_cross_det
    import dds_pkg::*;
#(
    parameter int HYST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] thr,
    output logic              rise_pulse
);

    localparam logic [DATA_W:0] C_HYST = (DATA_W+1)'(HYST);

    cross_state_e      state_q, state_d;
    logic [DATA_W:0]   w_hi_sum;
    logic [DATA_W:0]   w_lo_diff;
    logic [DATA_W-1:0] w_thr_hi;
    logic [DATA_W-1:0] w_thr_lo;

    // Carry out / borrow out of the 11-bit ops select the saturated bound.
    assign w_hi_sum  = {1'b0, thr} + C_HYST;
    assign w_lo_diff = {1'b0, thr} - C_HYST;
    assign w_thr_hi  = w_hi_sum[DATA_W]  ? C_DATA_MAX   : w_hi_sum[DATA_W-1:0];
    assign w_thr_lo  = w_lo_diff[DATA_W] ? '0           : w_lo_diff[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CROSS_LOW;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rise_pulse = 1'b0;
        if (sample_valid) begin
            case (state_q)
                CROSS_LOW: begin
                    if (sample_data >= w_thr_hi) begin
                        state_d    = CROSS_HIGH;
                        rise_pulse = 1'b1;
                    end
                end
                CROSS_HIGH: begin
                    if (sample_data <= w_thr_lo) begin
                        state_d = CROSS_LOW;
                    end
                end
                default: state_d = CROSS_LOW;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/wave_measure.sv
// ============================================================================
// wave_measure : gated frequency (rising crossings) and Vpp measurement
// Optional macro WAVE_MEASURE_AVG_EN : meas_freq averaged over last 4 windows
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module wave_measure
    import dds_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int GATE_CYCLES = CLK_FREQ,
    parameter int HYST        = 16,
    parameter int MID_INIT    = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [FREQ_W-1:0] meas_freq,
    output logic [DATA_W-1:0] meas_vpp,
    output logic              meas_valid,
    output logic              meas_nosig
);

    localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic [GATE_W-1:0] gate_q;
    logic [DATA_W-1:0] thr_q;
    logic [FREQ_W-1:0] cnt_q;
    logic [DATA_W-1:0] min_q, max_q;
    logic              seen_q;
    logic [FREQ_W-1:0] freq_q;
    logic [DATA_W-1:0] vpp_q;
    logic              valid_q, nosig_q;

    logic              w_wrap, w_rise, w_seen_d;
    logic [FREQ_W-1:0] w_cnt_d, w_freq_pub;
    logic [DATA_W-1:0] w_min_d, w_max_d;
    logic [DATA_W:0]   w_mid_sum;

    wave_cross_det #(
        .HYST (HYST)
    ) u_cross_det (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .thr          (thr_q),
        .rise_pulse   (w_rise)
    );

    // Window state including this cycle's sample, so the wrap cycle counts.
    assign w_wrap    = (gate_q == GATE_LAST);
    assign w_cnt_d   = (w_rise && (cnt_q != C_FREQ_MAX)) ? cnt_q + FREQ_W'(1) : cnt_q;
    assign w_min_d   = (sample_valid && (sample_data < min_q)) ? sample_data : min_q;
    assign w_max_d   = (sample_valid && (sample_data > max_q)) ? sample_data : max_q;
    assign w_seen_d  = seen_q | sample_valid;
    assign w_mid_sum = {1'b0, w_min_d} + {1'b0, w_max_d};

`ifdef WAVE_MEASURE_AVG_EN
    logic [FREQ_W-1:0] hist_q [3];
    logic [1:0]        ncl_q;
    logic [FREQ_W+1:0] w_avg_sum;

    // Three earlier counts plus the closing one form the four-window sum.
    assign w_avg_sum  = {2'b00, w_cnt_d} + {2'b00, hist_q[0]}
                      + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    assign w_freq_pub = (ncl_q == 2'd3) ? w_avg_sum[FREQ_W+1:2] : w_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q[0] <= '0;
            hist_q[1] <= '0;
            hist_q[2] <= '0;
            ncl_q     <= 2'd0;
        end else if (w_wrap) begin
            hist_q[0] <= w_cnt_d;
            hist_q[1] <= hist_q[0];
            hist_q[2] <= hist_q[1];
            if (ncl_q != 2'd3) begin
                ncl_q <= ncl_q + 2'd1;
            end
        end
    end
`else
    assign w_freq_pub = w_cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q  <= '0;
            thr_q   <= DATA_W'(MID_INIT);
            cnt_q   <= '0;
            min_q   <= C_DATA_MAX;
            max_q   <= '0;
            seen_q  <= 1'b0;
            freq_q  <= '0;
            vpp_q   <= '0;
            valid_q <= 1'b0;
            nosig_q <= 1'b0;
        end else begin
            valid_q <= w_wrap;
            if (w_wrap) begin
                gate_q  <= '0;
                freq_q  <= w_freq_pub;
                vpp_q   <= w_seen_d ? (w_max_d - w_min_d) : '0;
                nosig_q <= (w_cnt_d == '0);
                cnt_q   <= '0;
                min_q   <= C_DATA_MAX;
                max_q   <= '0;
                seen_q  <= 1'b0;
                if (w_seen_d) begin
                    thr_q <= w_mid_sum[DATA_W:1];
                end
            end else begin
                gate_q <= gate_q + GATE_W'(1);
                cnt_q  <= w_cnt_d;
                min_q  <= w_min_d;
                max_q  <= w_max_d;
                seen_q <= w_seen_d;
            end
        end
    end

    assign meas_freq  = freq_q;
    assign meas_vpp   = vpp_q;
    assign meas_valid = valid_q;
    assign meas_nosig = nosig_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_measure.sv
// ============================================================================
// tb_wave_measure : randomized windows checked against a behavioural model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wave_measure;

    localparam int GC   = 1000;
    localparam int HYST = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [9:0]  sample_data = '0;
    logic [19:0] meas_freq;
    logic [9:0]  meas_vpp;
    logic        meas_valid;
    logic        meas_nosig;

    always #5 clk = ~clk;

    wave_measure #(
        .CLK_FREQ    (50_000_000),
        .GATE_CYCLES (GC),
        .HYST        (HYST),
        .MID_INIT    (512)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .meas_freq    (meas_freq),
        .meas_vpp     (meas_vpp),
        .meas_valid   (meas_valid),
        .meas_nosig   (meas_nosig)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: window contents kept as a list of samples.
    int m_gate, m_cnt, m_thr;
    bit m_high;
    int m_win[$];
    int m_hist[$];
    int e_freq, e_vpp, e_valid, e_nosig;

    task automatic model_reset();
        m_gate = 0; m_cnt = 0; m_thr = 512; m_high = 0;
        m_win.delete(); m_hist.delete();
        e_freq = 0; e_vpp = 0; e_valid = 0; e_nosig = 0;
    endtask

    task automatic model_step(input bit v, input int d);
        int hi, lo, mn, mx, s;
        e_valid = 0;
        if (v) begin
            hi = (m_thr + HYST > 1023) ? 1023 : m_thr + HYST;
            lo = (m_thr - HYST < 0) ? 0 : m_thr - HYST;
            if (!m_high && d >= hi) begin
                m_high = 1;
                if (m_cnt < (1 << 20) - 1) m_cnt++;
            end else if (m_high && d <= lo) begin
                m_high = 0;
            end
            m_win.push_back(d);
        end
        if (m_gate == GC - 1) begin
            mn = 1023; mx = 0;
            foreach (m_win[i]) begin
                if (m_win[i] < mn) mn = m_win[i];
                if (m_win[i] > mx) mx = m_win[i];
            end
            e_vpp   = (m_win.size() > 0) ? mx - mn : 0;
            e_nosig = (m_cnt == 0);
            e_valid = 1;
            m_hist.push_front(m_cnt);
`ifdef WAVE_MEASURE_AVG_EN
            if (m_hist.size() >= 4) begin
                s = m_hist[0] + m_hist[1] + m_hist[2] + m_hist[3];
                e_freq = s / 4;
            end else begin
                e_freq = m_cnt;
            end
`else
            s = 0;
            e_freq = m_cnt + s;
`endif
            if (m_win.size() > 0) m_thr = (mn + mx) / 2;
            m_win.delete();
            m_cnt = 0;
            m_gate = 0;
        end else begin
            m_gate++;
        end
    endtask

    // Phases: 0 square, 1 noisy triangle, 2 idle, 3 crossing on last cycle,
    // 4 constant high, 5 random.
    task automatic gen(input int ph, input int k, output bit v, output int d);
        int p, n;
        v = 1; d = 0;
        case (ph)
            0: d = ((k % 100) < 50) ? 0 : 1023;
            1: begin
                p = k % 250;
                d = (p < 125) ? 200 + (p * 600) / 125 : 800 - ((p - 125) * 600) / 125;
                n = int'($urandom_range(20)) - 10;
                d = d + n;
                if (d < 0) d = 0;
                if (d > 1023) d = 1023;
            end
            2: begin v = 0; d = int'($urandom % 1024); end
            3: d = (k == GC - 1) ? 1000 : 100;
            4: d = 1000;
            default: begin
                v = ($urandom % 4) != 0;
                d = int'($urandom % 1024);
            end
        endcase
    endtask

    task automatic run_window(input int ph, input int ncyc);
        bit v;
        int d;
        for (int k = 0; k < ncyc; k++) begin
            gen(ph, k, v, d);
            sample_valid = v;
            sample_data  = 10'(d);
            @(posedge clk);
            model_step(v, d);
            #1;
            check_val("valid", 32'(meas_valid), 32'(e_valid));
            check_val("freq",  32'(meas_freq),  32'(e_freq));
            check_val("vpp",   32'(meas_vpp),   32'(e_vpp));
            check_val("nosig", 32'(meas_nosig), 32'(e_nosig));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_freq",  32'(meas_freq),  32'd0);
        check_val("rst_vpp",   32'(meas_vpp),   32'd0);
        check_val("rst_valid", 32'(meas_valid), 32'd0);
        check_val("rst_nosig", 32'(meas_nosig), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < 2; w++) begin
            run_window(0, GC);
            check_val("sq_freq",  32'(meas_freq),  32'd10);
            check_val("sq_vpp",   32'(meas_vpp),   32'd1023);
            check_val("sq_nosig", 32'(meas_nosig), 32'd0);
            check_val("sq_valid", 32'(meas_valid), 32'd1);
        end

        for (int w = 0; w < 3; w++) begin
            run_window(1, GC);
            check_val("tri_freq", 32'(meas_freq), 32'd4);
            check_val("tri_vpp_range", 32'(meas_vpp >= 10'd580 && meas_vpp <= 10'd620), 32'd1);
        end

        run_window(2, GC);
        check_val("idle_freq",  32'(meas_freq),  32'd0);
        check_val("idle_vpp",   32'(meas_vpp),   32'd0);
        check_val("idle_nosig", 32'(meas_nosig), 32'd1);

        run_window(3, GC);
        check_val("edge999_freq", 32'(meas_freq), 32'd1);
        check_val("edge999_vpp",  32'(meas_vpp),  32'd900);
        run_window(4, GC);
        check_val("after_edge_freq",  32'(meas_freq),  32'd0);
        check_val("after_edge_nosig", 32'(meas_nosig), 32'd1);
        check_val("after_edge_vpp",   32'(meas_vpp),   32'd0);

        for (int w = 0; w < 3; w++) run_window(5, GC);

        run_window(5, 500);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_freq",  32'(meas_freq),  32'd0);
        check_val("async_rst_vpp",   32'(meas_vpp),   32'd0);
        check_val("async_rst_valid", 32'(meas_valid), 32'd0);
        check_val("async_rst_nosig", 32'(meas_nosig), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("in_rst_valid", 32'(meas_valid), 32'd0);
        rst_n = 1'b1;

        run_window(5, GC);
        check_val("post_rst_valid", 32'(meas_valid), 32'd1);
        run_window(0, GC);
        run_window(5, GC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
